// File: rtl/mux_word_serializer_pkg.sv
// Shared types and constants for the word serializer slice.
// Bit order is selected by SER_MSB_FIRST_EN (undefined: LSB first).
package mux_ser_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned WORD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

`ifdef SER_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] SEL_START = 3'd7;
  localparam logic [SEL_W-1:0] SEL_END   = 3'd0;
  localparam bit               SEL_DOWN  = 1'b1;
`else
  localparam logic [SEL_W-1:0] SEL_START = 3'd0;
  localparam logic [SEL_W-1:0] SEL_END   = 3'd7;
  localparam bit               SEL_DOWN  = 1'b0;
`endif

endpackage

// File: rtl/mux_word_serializer_if.sv
// Load and serial-stream bundle for mux_word_serializer.
// master: upstream/downstream environment; slave: the serializer.
interface mux_word_serializer_if;
  import mux_ser_pkg::*;

  logic              load_valid;
  logic [WORD_W-1:0] load_data;
  logic              load_ready;
  logic              ser_valid;
  logic              ser_data;
  logic              ser_last;
  logic              ser_ready;
  logic [SEL_W-1:0]  sel;
  logic              busy;

  modport master (
    output load_valid, load_data, ser_ready,
    input  load_ready, ser_valid, ser_data, ser_last, sel, busy
  );

  modport slave (
    input  load_valid, load_data, ser_ready,
    output load_ready, ser_valid, ser_data, ser_last, sel, busy
  );

endinterface

// File: rtl/mux_word_serializer_sel_counter.sv
// Loadable 3-bit select counter; direction follows SER_MSB_FIRST_EN.
// Stops at the end index and only returns to start through load.
module mux_sel_counter
  import mux_ser_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             active_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             is_end_o,
  output logic             last_o
);

  logic [SEL_W-1:0] sel_q, sel_d;

  assign is_end_o = (sel_q == SEL_END);
  assign last_o   = active_i & is_end_o;
  assign sel_o    = sel_q;

  always_comb begin
    sel_d = sel_q;
    if (load_i) begin
      sel_d = SEL_START;
    end else if (en_i && !is_end_o) begin
      sel_d = SEL_DOWN ? (sel_q - 3'd1) : (sel_q + 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= SEL_START;
    end else begin
      sel_q <= sel_d;
    end
  end

endmodule

// File: rtl/mux_word_serializer.sv
// Word-to-bit serializer driving the 8:1 select stage (IDLE -> SHIFT -> GAP).
// Optional SER_MSB_FIRST_EN reverses bit order (see mux_ser_pkg).
module mux_word_serializer
  import mux_ser_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_word_serializer_if.slave  bus
);

  localparam logic [3:0] GAP_INIT = (IDLE_GAP == 0) ? 4'd0 : 4'(IDLE_GAP - 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [3:0]        gap_q, gap_d;

  logic             load_ready;
  logic             ser_valid;
  logic             load_fire;
  logic             bit_fire;
  logic             last_fire;
  logic             is_end;
  logic             ser_last;
  logic [SEL_W-1:0] sel;

  // Handshake outputs are gated by rst so nothing is offered during reset.
  assign load_ready = !rst && (state_q == ST_IDLE);
  assign ser_valid  = !rst && (state_q == ST_SHIFT);
  assign load_fire  = bus.load_valid && load_ready;
  assign bit_fire   = ser_valid && bus.ser_ready;
  assign last_fire  = bit_fire && is_end;

  mux_sel_counter u_sel (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_fire || last_fire),
    .en_i     (bit_fire),
    .active_i (ser_valid),
    .sel_o    (sel),
    .is_end_o (is_end),
    .last_o   (ser_last)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (load_fire) begin
          hold_d  = bus.load_data;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_fire) begin
          if (IDLE_GAP == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_INIT;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.ser_valid  = ser_valid;
  assign bus.ser_data   = hold_q[sel];
  assign bus.ser_last   = ser_last && !rst;
  assign bus.sel        = sel;
  assign bus.busy       = !rst && ((state_q == ST_SHIFT) || (state_q == ST_GAP));

endmodule

// File: tb/tb_mux_word_serializer.sv
// Directed bench for mux_word_serializer: IDLE_GAP=0 instance and IDLE_GAP=3 instance.
module tb_mux_word_serializer;

`ifdef SER_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif
  localparam logic [2:0] START = MSB ? 3'd7 : 3'd0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mux_word_serializer_if if0 ();
  mux_word_serializer_if if1 ();

  mux_word_serializer #(.IDLE_GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mux_word_serializer #(.IDLE_GAP(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Select index expected for the k-th bit of a word.
  function automatic logic [2:0] idx_of(input int k);
    return MSB ? 3'(7 - k) : 3'(k);
  endfunction

  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++; if (if0.load_ready !== 1'b0) begin n_fail++; $display("FAIL rst_load_ready got %b exp 0", if0.load_ready); end
    n_checks++; if (if0.ser_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ser_valid got %b exp 0", if0.ser_valid); end
    @(negedge clk); #1;
    n_checks++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", if0.busy); end
    n_checks++; if (if0.load_ready !== 1'b0) begin n_fail++; $display("FAIL rst_load_ready2 got %b exp 0", if0.load_ready); end
    rst = 1'b0; #1;
    n_checks++; if (if0.load_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_load_ready got %b exp 1", if0.load_ready); end
    n_checks++; if (if0.sel !== START) begin n_fail++; $display("FAIL post_rst_sel got %0d exp %0d", if0.sel, START); end
    n_checks++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy got %b exp 0", if0.busy); end
    n_checks++; if (if1.load_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_load_ready1 got %b exp 1", if1.load_ready); end
  endtask

  // Loads w on if0 with ser_ready=1 and checks all eight bits plus the return to IDLE.
  task automatic test_word(input string name, input logic [7:0] w);
    logic [2:0] ix;
    @(negedge clk);
    if0.load_valid = 1'b1; if0.load_data = w; if0.ser_ready = 1'b1; #1;
    n_checks++; if (if0.load_ready !== 1'b1) begin n_fail++; $display("FAIL %s_accept load_ready got %b exp 1", name, if0.load_ready); end
    @(negedge clk);
    if0.load_valid = 1'b0; if0.load_data = ~w;
    for (int k = 0; k < 8; k++) begin
      ix = idx_of(k); #1;
      n_checks++; if (if0.ser_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid k=%0d got %b exp 1", name, k, if0.ser_valid); end
      n_checks++; if (if0.sel !== ix) begin n_fail++; $display("FAIL %s_sel k=%0d got %0d exp %0d", name, k, if0.sel, ix); end
      n_checks++; if (if0.ser_data !== w[ix]) begin n_fail++; $display("FAIL %s_data k=%0d got %b exp %b", name, k, if0.ser_data, w[ix]); end
      n_checks++; if (if0.ser_last !== (k == 7)) begin n_fail++; $display("FAIL %s_last k=%0d got %b exp %b", name, k, if0.ser_last, (k == 7)); end
      n_checks++; if (if0.load_ready !== 1'b0) begin n_fail++; $display("FAIL %s_lr_busy k=%0d got %b exp 0", name, k, if0.load_ready); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (if0.load_ready !== 1'b1) begin n_fail++; $display("FAIL %s_done load_ready got %b exp 1", name, if0.load_ready); end
    n_checks++; if (if0.ser_valid !== 1'b0) begin n_fail++; $display("FAIL %s_done ser_valid got %b exp 0", name, if0.ser_valid); end
    n_checks++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL %s_done busy got %b exp 0", name, if0.busy); end
  endtask

  task automatic test_backpressure();
    logic [7:0] w;
    logic [2:0] ix;
    w = 8'h3C;
    @(negedge clk);
    if0.load_valid = 1'b1; if0.load_data = w; if0.ser_ready = 1'b1;
    @(negedge clk);
    if0.load_valid = 1'b0; if0.load_data = 8'h00;
    for (int k = 0; k < 8; k++) begin
      ix = idx_of(k);
      if (ix == 3'd2) begin
        if0.ser_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          n_checks++; if (if0.sel !== 3'd2) begin n_fail++; $display("FAIL bp_stall_sel s=%0d got %0d exp 2", s, if0.sel); end
          n_checks++; if (if0.ser_data !== 1'b1) begin n_fail++; $display("FAIL bp_stall_data s=%0d got %b exp 1", s, if0.ser_data); end
          n_checks++; if (if0.ser_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_valid s=%0d got %b exp 1", s, if0.ser_valid); end
          @(negedge clk);
        end
        if0.ser_ready = 1'b1;
      end
      #1;
      n_checks++; if (if0.sel !== ix) begin n_fail++; $display("FAIL bp_sel k=%0d got %0d exp %0d", k, if0.sel, ix); end
      n_checks++; if (if0.ser_data !== w[ix]) begin n_fail++; $display("FAIL bp_data k=%0d got %b exp %b", k, if0.ser_data, w[ix]); end
      n_checks++; if (if0.ser_last !== (k == 7)) begin n_fail++; $display("FAIL bp_last k=%0d got %b exp %b", k, if0.ser_last, (k == 7)); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (if0.load_ready !== 1'b1) begin n_fail++; $display("FAIL bp_done load_ready got %b exp 1", if0.load_ready); end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, gapc, ones, zeros_bad;
    acc1 = -1; acc2 = -1; gapc = 0; ones = 0; zeros_bad = 0;
    @(negedge clk);
    if1.ser_ready = 1'b1; if1.load_valid = 1'b1; if1.load_data = 8'hFF;
    for (int c = 0; c < 40 && acc2 < 0; c++) begin
      #1;
      if (if1.load_valid && if1.load_ready) begin
        if (acc1 < 0) acc1 = c; else acc2 = c;
      end
      if (acc1 >= 0 && acc2 < 0 && !if1.load_ready && !if1.ser_valid) gapc++;
      if (acc2 < 0 && if1.ser_valid && if1.ser_data) ones++;
      @(negedge clk);
      if (acc1 >= 0) if1.load_data = 8'h00;
    end
    if1.load_valid = 1'b0;
    n_checks++; if (acc1 !== 0) begin n_fail++; $display("FAIL b2b_first_accept got %0d exp 0", acc1); end
    n_checks++; if (acc2 - acc1 !== 12) begin n_fail++; $display("FAIL b2b_spacing got %0d exp 12", acc2 - acc1); end
    n_checks++; if (gapc !== 3) begin n_fail++; $display("FAIL b2b_gap_cycles got %0d exp 3", gapc); end
    n_checks++; if (ones !== 8) begin n_fail++; $display("FAIL b2b_word1_ones got %0d exp 8", ones); end
    for (int k = 0; k < 8; k++) begin
      #1;
      if (!(if1.ser_valid === 1'b1 && if1.ser_data === 1'b0)) zeros_bad++;
      @(negedge clk);
    end
    n_checks++; if (zeros_bad !== 0) begin n_fail++; $display("FAIL b2b_word2_bits bad=%0d exp 0", zeros_bad); end
    for (int g = 0; g < 3; g++) begin
      #1;
      n_checks++; if (if1.load_ready !== 1'b0 || if1.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_gap2 g=%0d lr=%b busy=%b exp 0/1", g, if1.load_ready, if1.busy); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (if1.load_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle load_ready got %b exp 1", if1.load_ready); end
  endtask

  task automatic test_reset_mid_word();
    logic saw_last;
    saw_last = 1'b0;
    @(negedge clk);
    if0.load_valid = 1'b1; if0.load_data = 8'h81; if0.ser_ready = 1'b1;
    @(negedge clk);
    if0.load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (if0.ser_last === 1'b1) saw_last = 1'b1;
      if (idx_of(k) == 3'd4) break;
      @(negedge clk);
    end
    n_checks++; if (if0.sel !== 3'd4) begin n_fail++; $display("FAIL rmid_sel got %0d exp 4", if0.sel); end
    rst = 1'b1; #1;
    n_checks++; if (if0.ser_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", if0.ser_valid); end
    if (if0.ser_last === 1'b1) saw_last = 1'b1;
    @(negedge clk); #1;
    if (if0.ser_last === 1'b1) saw_last = 1'b1;
    n_checks++; if (saw_last !== 1'b0) begin n_fail++; $display("FAIL rmid_no_last got %b exp 0", saw_last); end
    rst = 1'b0; #1;
    n_checks++; if (if0.load_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_load_ready got %b exp 1", if0.load_ready); end
    n_checks++; if (if0.ser_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_after_valid got %b exp 0", if0.ser_valid); end
    n_checks++; if (if0.sel !== START) begin n_fail++; $display("FAIL rmid_sel_start got %0d exp %0d", if0.sel, START); end
    test_word("rmid_new", 8'h01);
  endtask

  initial begin
    if0.load_valid = 1'b0; if0.load_data = '0; if0.ser_ready = 1'b1;
    if1.load_valid = 1'b0; if1.load_data = '0; if1.ser_ready = 1'b1;
    test_reset();
    test_word("basic", 8'hA5);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_word("msb_first", 8'h80);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
